// File: rtl/imu_filter_pkg.sv
// imu_filter_pkg: shared state encoding, width helpers and default sizes for the IMU moving-average filter.
package imu_filter_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int IMU_NUM_CH = 6;
  localparam int IMU_DATA_W = 10;
  localparam int IMU_DEPTH_LOG2 = 6;
  function automatic int sum_w(input int data_w, input int depth_log2);
    return data_w + depth_log2 + 1;
  endfunction
  function automatic int out_w(input int data_w);
    return data_w;
  endfunction
endpackage

// File: rtl/imu_sample_ring.sv
// imu_sample_ring: per-channel sample history, addressed {ch, wr_ptr}; combinational read, synchronous write.
module imu_sample_ring #(
  parameter int NUM_CH = 6,
  parameter int DATA_W = 10,
  parameter int DEPTH_LOG2 = 6,
  parameter int AW = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [AW-1:0]     raddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [NUM_CH * (1 << DEPTH_LOG2)];
  assign rdata = mem[raddr];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/imu_moving_average.sv
// imu_moving_average: windowed running-sum moving average over NUM_CH serially processed channels,
// with seeded warm-up, flush and raw bypass.
module imu_moving_average
  import imu_filter_pkg::*;
#(
  parameter int NUM_CH = IMU_NUM_CH,
  parameter int DATA_W = IMU_DATA_W,
  parameter int DEPTH_LOG2 = IMU_DEPTH_LOG2,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     flush,
  input  logic                     bypass,
  output logic [NUM_CH*DATA_W-1:0] filtered_out,
  output logic                     filtered_valid,
  output logic                     primed
);
  localparam int SW = sum_w(DATA_W, DEPTH_LOG2);
  localparam int OW = out_w(DATA_W);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  state_t state, state_nx;
  logic [CW-1:0] ch;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0] fill_cnt;
  logic live, seeded, seeding, flush_pend, byp_q;
  logic [NUM_CH*DATA_W-1:0] in_q, avg;
  logic [SW-1:0] sum [NUM_CH];
  logic [DATA_W-1:0] seed [NUM_CH];
  logic [DATA_W-1:0] new_s, old_s, rd;
  logic [SW-1:0] new_x, old_x;
  logic accept;
  assign sample_ready = live && state == IDLE;
  assign accept = sample_valid && sample_ready;
  assign primed = fill_cnt == FULL;
  assign new_s = in_q[ch*DATA_W +: DATA_W];
  assign old_s = primed ? rd : seed[ch];
  assign new_x = {{(SW-DATA_W){SIGNED != 0 && new_s[DATA_W-1]}}, new_s};
  assign old_x = {{(SW-DATA_W){SIGNED != 0 && old_s[DATA_W-1]}}, old_s};
  imu_sample_ring #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .AW(CW + DEPTH_LOG2)) u_ring (
    .clk(clk),
    .we(state == ACCUM),
    .waddr({ch, wr_ptr}),
    .raddr({ch, wr_ptr}),
    .wdata(new_s),
    .rdata(rd)
  );
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (SIGNED != 0) begin : g_s
      assign avg[g*OW +: OW] = OW'($signed(sum[g]) >>> DEPTH_LOG2);
    end else begin : g_u
      assign avg[g*OW +: OW] = OW'(sum[g] >> DEPTH_LOG2);
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (accept ? ACCUM : IDLE) :
               state == ACCUM ? (ch == CW'(NUM_CH - 1) ? DONE : ACCUM) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= 1'b0;
      ch <= '0;
      wr_ptr <= '0;
      fill_cnt <= '0;
      seeded <= 1'b0;
      seeding <= 1'b0;
      flush_pend <= 1'b0;
      byp_q <= 1'b0;
      in_q <= '0;
      filtered_out <= '0;
      filtered_valid <= 1'b0;
    end else begin
      live <= 1'b1;
      filtered_valid <= 1'b0;
      ch <= state == IDLE ? '0 : ch + CW'(1);
      if (state == IDLE && flush) begin
        seeded <= 1'b0;
        fill_cnt <= '0;
        wr_ptr <= '0;
      end
      // a flush arriving with the sample clears history first, so that sample becomes the seed
      if (accept) begin
        in_q <= sample_in;
        byp_q <= bypass;
        seeding <= flush || !seeded;
        seeded <= 1'b1;
      end
      if (state != IDLE && flush) flush_pend <= 1'b1;
      if (state == DONE) begin
        filtered_out <= byp_q ? in_q : avg;
        filtered_valid <= 1'b1;
        flush_pend <= 1'b0;
        if (flush_pend || flush) begin
          seeded <= 1'b0;
          fill_cnt <= '0;
          wr_ptr <= '0;
        end else if (!seeding) begin
          wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
          if (!primed) fill_cnt <= fill_cnt + (DEPTH_LOG2 + 1)'(1);
        end
      end
    end
  end
  // the seed stands in for every not-yet-filled slot, so the first output equals the first sample
  always_ff @(posedge clk)
    if (state == ACCUM) begin
      if (seeding) seed[ch] <= new_s;
      sum[ch] <= seeding ? new_x << DEPTH_LOG2 : sum[ch] + new_x - old_x;
    end
endmodule

// File: tb/tb_imu_moving_average.sv
// tb_imu_moving_average: scoreboard bench; stimulus pushes expected outputs, monitors pop and compare.
module tb_imu_moving_average;
  localparam int W = 60;
  typedef struct {logic [W-1:0] d; logic p;} exp_t;
  logic clk, rst;
  logic v, fl, byp, v2;
  logic [W-1:0] din, din2;
  logic rdy, fv, pr, rdy2, fv2, pr2;
  logic [W-1:0] fo, fo2;
  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int compared = 0, mism = 0;
  int cyc = 0, last_acc = 0;
  logic hold = 0;
  int hold_n = 0;

  imu_moving_average #(.NUM_CH(6), .DATA_W(10), .DEPTH_LOG2(3), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .sample_valid(v), .sample_ready(rdy), .sample_in(din),
    .flush(fl), .bypass(byp), .filtered_out(fo), .filtered_valid(fv), .primed(pr)
  );
  imu_moving_average #(.NUM_CH(6), .DATA_W(10), .DEPTH_LOG2(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .sample_valid(v2), .sample_ready(rdy2), .sample_in(din2),
    .flush(1'b0), .bypass(1'b0), .filtered_out(fo2), .filtered_valid(fv2), .primed(pr2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] rep(input int x);
    logic [W-1:0] r;
    for (int c = 0; c < 6; c++) r[c*10 +: 10] = 10'(x);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    compared++;
    if (a !== e) begin
      mism++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic push(input int u, input logic [W-1:0] d, input logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    if (u != 0) q1.push_back(e);
    else q0.push_back(e);
  endtask

  task automatic wait_rdy(input int u);
    int n;
    n = 0;
    @(negedge clk);
    while (!(u != 0 ? rdy2 : rdy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(u != 0 ? rdy2 : rdy)) begin
      compared++;
      mism++;
      $display("FAIL ready_timeout unit %0d: ready stayed 0, expected 1", u);
    end
  endtask

  task automatic send(input int u, input logic [W-1:0] d, input logic b, input logic f);
    wait_rdy(u);
    if (u != 0) begin
      v2 = 1;
      din2 = d;
    end else begin
      v = 1;
      din = d;
      byp = b;
      fl = f;
    end
    @(negedge clk);
    v = 0;
    v2 = 0;
    fl = 0;
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (v && rdy) begin
      if (hold) begin
        if (hold_n > 0) begin
          compared++;
          if (cyc + 1 - last_acc != 8) begin
            mism++;
            $display("FAIL accept_interval: got %0d expected 8", cyc + 1 - last_acc);
          end
        end
        hold_n++;
      end
      last_acc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && fv) begin
      compared++;
      if (q0.size() == 0) begin
        mism++;
        $display("FAIL unexpected_valid: got output %h, expected no pulse", fo);
      end else begin
        e0 = q0.pop_front();
        if (fo !== e0.d || pr !== e0.p) begin
          mism++;
          $display("FAIL out: got %h primed %b expected %h primed %b", fo, pr, e0.d, e0.p);
        end
      end
      compared++;
      if (cyc - last_acc != 7) begin
        mism++;
        $display("FAIL latency: got %0d expected 7", cyc - last_acc);
      end
    end
    if (!rst && fv2) begin
      compared++;
      if (q1.size() == 0) begin
        mism++;
        $display("FAIL unexpected_valid_s: got output %h, expected no pulse", fo2);
      end else begin
        e1 = q1.pop_front();
        if (fo2 !== e1.d || pr2 !== e1.p) begin
          mism++;
          $display("FAIL out_s: got %h primed %b expected %h primed %b", fo2, pr2, e1.d, e1.p);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] sd;
    int s, c, n;
    rst = 1; v = 0; fl = 0; byp = 0; v2 = 0; din = '0; din2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", fo, '0);
    chk("reset_valid", W'(fv), '0);
    chk("reset_primed", W'(pr), '0);
    chk("reset_ready", W'(rdy), '0);
    rst = 0;
    chk("ready_at_release", W'(rdy), '0);
    @(negedge clk);
    chk("ready_after_release", W'(rdy), W'(1));
    // step up from a seed of 0, then back down
    push(0, rep(0), 0);
    send(0, rep(0), 0, 0);
    for (int k = 1; k <= 8; k++) begin
      push(0, rep(100 * k), k == 8);
      send(0, rep(800), 0, 0);
    end
    for (int k = 1; k <= 9; k++) begin
      push(0, rep(k <= 8 ? 800 - 100 * k : 0), 1);
      send(0, rep(0), 0, 0);
    end
    // flush with sample reseeds at 100, then valid held high for seven sets
    push(0, rep(100), 0);
    send(0, rep(100), 0, 1);
    for (int k = 0; k < 7; k++) push(0, rep(100), 0);
    wait_rdy(0);
    hold = 1;
    v = 1;
    din = rep(100);
    repeat (56) @(negedge clk);
    v = 0;
    hold = 0;
    chk("hold_accepts", W'(hold_n), W'(7));
    push(0, rep(100), 1);
    send(0, rep(100), 0, 0);
    push(0, rep(513), 1);
    send(0, rep(513), 1, 0);
    push(0, rep(151), 1);
    send(0, rep(100), 0, 0);
    // flush during ACCUM: current set still produced, next sample reseeds
    push(0, rep(164), 0);
    send(0, rep(200), 0, 0);
    fl = 1;
    @(negedge clk);
    fl = 0;
    push(0, rep(37), 0);
    send(0, rep(37), 0, 0);
    wait_rdy(0);
    fl = 1;
    @(negedge clk);
    fl = 0;
    push(0, rep(300), 0);
    send(0, rep(300), 0, 0);
    push(0, rep(301), 0);
    send(0, rep(308), 0, 0);
    // wrap-around with incrementing samples, seed 1
    push(0, rep(1), 0);
    send(0, rep(1), 0, 1);
    for (int k = 2; k <= 20; k++) begin
      s = 0;
      c = 0;
      for (int j = k; j >= 2 && c < 8; j--) begin
        s += j;
        c++;
      end
      s += 8 - c;
      push(0, rep(s / 8), k >= 9);
      send(0, rep(k), 0, 0);
    end
    repeat (10) @(negedge clk);
    chk("wrap_last", fo, rep(16));
    // reset in the middle of ACCUM aborts the set
    send(0, rep(55), 0, 0);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("abort_out", fo, '0);
    chk("abort_valid", W'(fv), '0);
    chk("abort_primed", W'(pr), '0);
    chk("abort_ready", W'(rdy), '0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    chk("abort_ready_release", W'(rdy), '0);
    @(negedge clk);
    chk("abort_ready_after", W'(rdy), W'(1));
    repeat (12) @(negedge clk);
    push(0, rep(9), 0);
    send(0, rep(9), 0, 0);
    // signed instance: -8, 511, -512 seeds then a zero sample
    sd = '0;
    sd[9:0] = 10'h3F8;
    sd[19:10] = 10'h1FF;
    sd[29:20] = 10'h200;
    push(1, sd, 0);
    send(1, sd, 0, 0);
    sd[9:0] = 10'h3F9;
    sd[19:10] = 10'h1BF;
    sd[29:20] = 10'h240;
    push(1, sd, 0);
    send(1, '0, 0, 0);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", W'(q0.size() + q1.size()), '0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule

// File: doc/imu_moving_average.md
Name: imu_moving_average

Overview:
- Parametrised windowed moving-average low-pass filter for IMU sensor channels. It sits between the IMU read engine and the motor-control logic.
- Removes transients before sensor data reaches the motor path.
- Differences from the previous filter generation:
  - generic channel count, sample width and window depth;
  - synchronous single-clock design with a valid/ready handshake;
  - signed-data support;
  - running-sum arithmetic, with no full re-summation per sample;
  - seeded warm-up, flush and bypass.
- Channels are processed serially through one shared adder/subtractor.

Parameters:
- NUM_CH, 6: number of channels. Channel 0 is in the LSBs of the packed buses.
- DATA_W, 10: bits per channel sample.
- DEPTH_LOG2, 6: window depth is 2**DEPTH_LOG2 samples (64). Minimum 1, maximum 8.
- SIGNED, 0: 1 means samples are two's complement. 0 means unsigned.

Ports:
- Clock, in, 1: system clock. Everything is rising-edge.
- Reset, in, 1: asynchronous, active-high reset.
- SampleValid, in, 1: a new sample set is present on SampleIn.
- SampleReady, out, 1: block can accept a sample set.
- SampleIn, in, NUM_CH*DATA_W: packed raw samples.
- Flush, in, 1: single-cycle request to discard filter history.
- Bypass, in, 1: 1 means output raw samples. 0 means output averaged samples.
- FilteredOut, out, NUM_CH*DATA_W: packed filtered samples, registered.
- FilteredValid, out, 1: one-cycle pulse when FilteredOut updates.
- Primed, out, 1: window is fully populated with real samples.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; FilteredOut = 0; FilteredValid = 0; Primed = 0.
  - SampleReady = 0 while Reset is high, 1 from the first edge after release.
  - Write pointer WrPtr = 0; fill counter FillCnt = 0; Seeded = 0; flush-pending = 0.
  - Buffer contents are don't-care.
- Handshake: a transfer occurs on an edge where SampleValid && SampleReady. SampleReady = 1 only in IDLE. SampleIn is captured into an input register at the accept edge E0.
- States:
  - IDLE: waits for a transfer, then goes to ACCUM with ch = 0.
  - ACCUM: one channel per edge, E1..E_NUM_CH. On the last channel goes to DONE.
  - DONE: at edge E_NUM_CH+1, FilteredOut and FilteredValid are registered, WrPtr/FillCnt are updated, and state returns to IDLE.
- Timing:
  - Latency: FilteredValid is high for the one cycle following E_NUM_CH+1.
  - Earliest next accept is E_NUM_CH+2, so sustained throughput is one set per NUM_CH+2 clocks.
- Per-channel arithmetic, in ACCUM for channel c:
  - oldest = (FillCnt == DEPTH) ? Buf[c][WrPtr] : Seed[c].
  - Sum[c] <= Sum[c] + new - oldest.
  - Buf[c][WrPtr] <= new.
- Seeding: on the first accepted sample after reset or flush (Seeded == 0):
  - Seed[c] = new and Sum[c] = new << DEPTH_LOG2. The first output equals the first sample.
  - Seeded = 1.
- Widths and output scaling:
  - Sum width is DATA_W + DEPTH_LOG2 + 1. Overflow is impossible.
  - Output = Sum >> DEPTH_LOG2. Arithmetic shift when SIGNED (rounds toward −inf), logical shift otherwise. No saturation needed.
- WrPtr wraps modulo DEPTH. FillCnt saturates at DEPTH. Primed = (FillCnt == DEPTH).
- Bypass:
  - Sampled at E0. FilteredOut = captured raw sample, with identical latency and handshake.
  - Sum, buffer, seed and pointer updates continue, so releasing Bypass gives a correct average immediately.
- Flush:
  - In IDLE: clears Seeded, FillCnt, WrPtr and Primed at that edge.
  - Flush together with SampleValid in IDLE: flush applies first, and the same sample is accepted as the new seed.
  - Flush during ACCUM/DONE: latched as pending and applied at the DONE edge, after the current output is produced.
  - FilteredOut retains its last value across a flush.
- Reset mid-operation: immediate abort. No FilteredValid is emitted and all state is cleared as above.
- SampleIn changes while not ready are ignored.

Decomposition:
- Shared package imu_filter_pkg:
  - state enum (IDLE, ACCUM, DONE);
  - sum-width and output-width constant functions;
  - default NUM_CH/DATA_W/DEPTH_LOG2 constants for the IMU instance.
- One sub-module: imu_sample_ring.
  - NUM_CH×DEPTH×DATA_W storage, indexed {ch, WrPtr}.
  - One read and one write port, combinational read, synchronous write.
  - Keeps memory inference separate from the control FSM and arithmetic.

Test Plan (NUM_CH=6, DATA_W=10, DEPTH_LOG2=3 unless stated):
- Reset and idle outputs:
  - Stimulus: assert Reset mid-run during ACCUM.
  - Required: FilteredOut=0, FilteredValid never pulses for the aborted set, SampleReady=1 one edge after release, Primed=0.
- Seeding and step response:
  - Stimulus: seed all channels with 0, then eight sets of 800.
  - Required: outputs are 0, 100, 200, …, 800. Primed rises with the 8th post-seed sample.
  - Stimulus: then nine sets of 0.
  - Required: outputs fall by 100 per sample back to 0.
- Signed:
  - Stimulus: SIGNED=1, seed ch0 = 0x3F8 (−8), then one sample of 0.
  - Required: Sum = −56, output 0x3F9 (−7).
- Handshake and timing:
  - Stimulus: SampleValid held high continuously.
  - Required: accepts exactly every 8 clocks. FilteredValid pulses 7 edges after each accept. SampleReady is low for 7 cycles.
- Flush and bypass:
  - Stimulus: Flush during ACCUM.
  - Required: the current output is produced, then the next sample reseeds (output equals that sample, Primed=0).
  - Stimulus: Bypass=1 with sample 513 after a window of 100s.
  - Required: output 513.
  - Stimulus: Bypass=0 with a further 100.
  - Required: output (6×100 + 513 + 100)/8 = 151.
- Wrap-around:
  - Stimulus: 20 sets of incrementing values 1..20.
  - Required: each output equals floor(sum of the last 8)/8, e.g. output after sample 20 = 132/8 = 16. WrPtr wraps cleanly.
